// File: rtl/pito_dmem_arbiter.sv
// pito_dmem_arbiter: round-robin core/host sharing of one single-port data RAM with host bus-lock
module pito_dmem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [AW-1:0]     core_addr,
    input  logic [DW-1:0]     core_wdata,
    input  logic [DW/8-1:0]   core_be,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DW-1:0]     core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DW-1:0]     host_wdata,
    input  logic [DW/8-1:0]   host_be,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DW-1:0]     host_rdata,
    output logic              mem_en,
    output logic [DW/8-1:0]   mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [31:0]       stall_cnt
);
    localparam int BW = DW / 8;
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK);

    logic          rr_ptr;
    logic          host_prev;
    logic          rd_q;
    logic          rd_host_q;
    logic [LW-1:0] lock_cnt;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          lock_win;
    logic          force_core;

    // grant decision: lock streak keeps the host, exhausted streak hands over to core, else round-robin
    always_comb begin
        lock_win   = host_prev && host_lock && host_req && (lock_cnt < LMAX);
        force_core = core_req && (lock_cnt == LMAX);
        host_gnt   = host_req && (!core_req || lock_win || (rr_ptr && !force_core));
        core_gnt   = core_req && !host_gnt;
    end

    // steer the winner onto the RAM port; idle port is driven to zero
    always_comb begin
        mem_en    = core_gnt || host_gnt;
        mem_we    = host_gnt ? {BW{host_we}} & host_be : core_gnt ? {BW{core_we}} & core_be : '0;
        mem_addr  = host_gnt ? host_addr : core_gnt ? core_addr : '0;
        mem_wdata = host_gnt ? host_wdata : core_gnt ? core_wdata : '0;
    end

    // read return goes to the side that owned the previous read; the other side keeps its last data
    always_comb begin
        core_rvalid = rd_q && !rd_host_q;
        host_rvalid = rd_q && rd_host_q;
        core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
        host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
    end

    // arbitration history, lock streak, read-return tags and stall statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b0;
            host_prev    <= 1'b0;
            rd_q         <= 1'b0;
            rd_host_q    <= 1'b0;
            lock_cnt     <= '0;
            stall_cnt    <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            if (mem_en) rr_ptr <= core_gnt;
            host_prev <= host_gnt;
            rd_q      <= mem_en && !(host_gnt ? host_we : core_we);
            rd_host_q <= host_gnt;
            lock_cnt  <= (!host_lock || core_gnt) ? '0 :
                         (host_gnt && host_prev && core_req && lock_cnt < LMAX) ? lock_cnt + LW'(1) : lock_cnt;
            stall_cnt <= (core_req && !core_gnt && stall_cnt != 32'hFFFF_FFFF) ? stall_cnt + 32'd1 : stall_cnt;
            if (core_rvalid) core_rdata_q <= mem_rdata;
            if (host_rvalid) host_rdata_q <= mem_rdata;
        end
    end
endmodule
